// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers behind ID and
// derives the load-use stall, operand forward selects and a registered
// per-register busy mask for the 5-stage pipeline.
module hazard_scoreboard #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_STG = 1,
  parameter int SW        = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_reg_wr,
  input  logic            id_mem_rd,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic [SW-1:0]   fwd_rs,
  output logic [SW-1:0]   fwd_rt,
  output logic [NREG-1:0] busy_mask
);

  // Stage entries, index 0 = youngest (EX), DEPTH-1 = oldest (WB)
  logic          vld_q [DEPTH];
  logic [AW-1:0] rd_q  [DEPTH];
  logic          ld_q  [DEPTH];
  logic          vld_d [DEPTH];
  logic [AW-1:0] rd_d  [DEPTH];
  logic          ld_d  [DEPTH];

  // Per-register count of in-flight writers
  logic [SW-1:0] cnt_q [NREG];
  logic [SW-1:0] cnt_d [NREG];

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic rs_load_use;
  logic rt_load_use;
  logic new_wr;

  assign busy_mask = busy_q;

  // Youngest matching entry wins: scan oldest to youngest so the last hit sticks
  always_comb begin
    fwd_rs      = '0;
    fwd_rt      = '0;
    rs_load_use = 1'b0;
    rt_load_use = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (id_use_rs && (id_rs != '0) && vld_q[i] && (rd_q[i] == id_rs)) begin
        fwd_rs      = SW'(i + 1);
        rs_load_use = ld_q[i] && (i < LOAD_LAT);
      end
      if (id_use_rt && (id_rt != '0) && vld_q[i] && (rd_q[i] == id_rt)) begin
        fwd_rt      = SW'(i + 1);
        rt_load_use = ld_q[i] && (i < LOAD_LAT);
      end
    end
  end

  // Stall only for a real, non-flushed instruction; a taken branch redirects
  // the front end, so holding it for a load-use hazard would be wrong
  always_comb begin
    stall  = id_valid && !flush && (rs_load_use || rt_load_use);
    issue  = id_valid && !stall && !flush;
    new_wr = issue && id_reg_wr && (id_rd != '0);
  end

  // Shift the pipe; a flush kills the youngest in-flight entries (the
  // instructions fetched behind the branch) as they move down
  always_comb begin
    vld_d[0] = new_wr;
    rd_d[0]  = id_rd;
    ld_d[0]  = id_mem_rd;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1] && !(flush && ((i - 1) < FLUSH_STG));
      rd_d[i]  = rd_q[i-1];
      ld_d[i]  = ld_q[i-1];
    end
  end

  // Writer counters: +1 on issue, -1 on retire, -1 per killed entry
  always_comb begin
    int delta;
    for (int r = 0; r < NREG; r++) begin
      delta = 0;
      if (new_wr && (id_rd == AW'(r)))
        delta = delta + 1;
      if (vld_q[DEPTH-1] && (rd_q[DEPTH-1] == AW'(r)))
        delta = delta - 1;
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (flush && (i < FLUSH_STG) && vld_q[i] && (rd_q[i] == AW'(r)))
          delta = delta - 1;
      end
      if (r == 0)
        cnt_d[r] = '0;
      else
        cnt_d[r] = SW'(int'(cnt_q[r]) + delta);
      busy_d[r] = (r != 0) && (cnt_d[r] != '0);
    end
  end

  // State registers; reset drops every in-flight entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        rd_q[i]  <= '0;
        ld_q[i]  <= 1'b0;
      end
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= vld_d[i];
        rd_q[i]  <= rd_d[i];
        ld_q[i]  <= ld_d[i];
      end
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector table, hand-written
// flush/reset sequences and randomized traffic against a queue-based model.
module tb_hazard_scoreboard;

  localparam int NREG      = 32;
  localparam int AW        = 5;
  localparam int DEPTH     = 3;
  localparam int LOAD_LAT  = 2;
  localparam int FLUSH_STG = 1;
  localparam int SW        = 2;

  logic            clk;
  logic            reset;
  logic            id_valid;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic [AW-1:0]   id_rd;
  logic            id_reg_wr;
  logic            id_mem_rd;
  logic            flush;
  logic            stall;
  logic            issue;
  logic [SW-1:0]   fwd_rs;
  logic [SW-1:0]   fwd_rt;
  logic [NREG-1:0] busy_mask;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
    .FLUSH_STG(FLUSH_STG), .SW(SW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .flush(flush),
    .stall(stall), .issue(issue), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          use_rs;
    logic          use_rt;
    logic [AW-1:0] rd;
    logic          reg_wr;
    logic          mem_rd;
    logic          fl;
    logic          e_stall;
    logic          e_issue;
    logic [SW-1:0] e_fwd_rs;
    logic [SW-1:0] e_fwd_rt;
  } vec_t;

  // In-flight instruction as the model sees it: index 0 = youngest
  typedef struct {
    logic          vld;
    logic [AW-1:0] rd;
    logic          ld;
  } inst_t;

  inst_t mq[$];
  vec_t  cur;
  vec_t  vecs[14];
  vec_t  dep;
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input int rd,
                              input logic wr, input logic ld, input logic fl,
                              input logic es, input logic ei, input int efs, input int eft);
    vec_t x;
    x.valid = v; x.rs = AW'(rs); x.rt = AW'(rt); x.use_rs = urs; x.use_rt = urt;
    x.rd = AW'(rd); x.reg_wr = wr; x.mem_rd = ld; x.fl = fl;
    x.e_stall = es; x.e_issue = ei; x.e_fwd_rs = SW'(efs); x.e_fwd_rt = SW'(eft);
    return x;
  endfunction

  task automatic modelReset();
    inst_t b;
    b.vld = 1'b0; b.rd = '0; b.ld = 1'b0;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(b);
  endtask

  // Find the youngest in-flight writer of a register, -1 if none
  function automatic int youngestWriter(input logic use_it, input logic [AW-1:0] r);
    if (!use_it || r == '0) return -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].vld && mq[i].rd == r) return i;
    return -1;
  endfunction

  function automatic void modelEval(input vec_t v, output logic s, output logic iss,
                                    output logic [SW-1:0] frs, output logic [SW-1:0] frt);
    int  hs, ht;
    logic lu;
    hs = youngestWriter(v.use_rs, v.rs);
    ht = youngestWriter(v.use_rt, v.rt);
    lu = 1'b0;
    if (hs >= 0 && mq[hs].ld && hs < LOAD_LAT) lu = 1'b1;
    if (ht >= 0 && mq[ht].ld && ht < LOAD_LAT) lu = 1'b1;
    s   = v.valid && !v.fl && lu;
    iss = v.valid && !s && !v.fl;
    frs = SW'(hs + 1);
    frt = SW'(ht + 1);
  endfunction

  function automatic logic [NREG-1:0] modelBusy();
    logic [NREG-1:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].vld && mq[i].rd != '0) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cur       = v;
    id_valid  = v.valid;
    id_rs     = v.rs;
    id_rt     = v.rt;
    id_use_rs = v.use_rs;
    id_use_rt = v.use_rt;
    id_rd     = v.rd;
    id_reg_wr = v.reg_wr;
    id_mem_rd = v.mem_rd;
    flush     = v.fl;
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic s, iss;
    logic [SW-1:0] frs, frt;
    modelEval(cur, s, iss, frs, frt);
    checkOutput({tag, ".stall"},  32'(stall),     32'(s));
    checkOutput({tag, ".issue"},  32'(issue),     32'(iss));
    checkOutput({tag, ".fwd_rs"}, 32'(fwd_rs),    32'(frs));
    checkOutput({tag, ".fwd_rt"}, 32'(fwd_rt),    32'(frt));
    checkOutput({tag, ".busy"},   32'(busy_mask), 32'(modelBusy()));
  endtask

  // Advance the model and the DUT through one rising edge
  task automatic advance();
    logic s, iss;
    logic [SW-1:0] frs, frt;
    inst_t n;
    modelEval(cur, s, iss, frs, frt);
    if (cur.fl)
      for (int i = 0; i < FLUSH_STG && i < mq.size(); i++) mq[i].vld = 1'b0;
    n.vld = iss && cur.reg_wr && cur.rd != '0;
    n.rd  = cur.rd;
    n.ld  = cur.mem_rd;
    mq.push_front(n);
    void'(mq.pop_back());
    @(negedge clk);
  endtask

  task automatic step(input vec_t v, input string tag);
    applyStimulus(v);
    checkModel(tag);
    advance();
  endtask

  initial begin
    vec_t idle;
    vec_t rv;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // add r3 then readers of r3; lw r5 then dependent add; r7 writers; r0 writes
    vecs[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 1, 0, 0);
    vecs[1]  = mk(1, 3, 2, 1, 1, 4, 1, 0, 0,  0, 1, 1, 0);
    vecs[2]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0);
    vecs[3]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 1, 3, 0);
    vecs[4]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    vecs[5]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 1, 0, 0);
    vecs[6]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0,  1, 0, 1, 0);
    vecs[7]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0,  1, 0, 2, 0);
    vecs[8]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0,  0, 1, 3, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 1, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 1, 0, 0);
    vecs[11] = mk(1, 7, 7, 0, 1, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0);
    vecs[13] = mk(1, 0, 0, 1, 1, 8, 0, 0, 0,  0, 1, 0, 0);

    reset = 1'b0;
    modelReset();
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.stall",  32'(stall),     32'd0);
    checkOutput("reset.issue",  32'(issue),     32'd1);
    checkOutput("reset.fwd_rs", 32'(fwd_rs),    32'd0);
    checkOutput("reset.fwd_rt", 32'(fwd_rt),    32'd0);
    checkOutput("reset.busy",   32'(busy_mask), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("vec%0d.stall", k),  32'(stall),  32'(vecs[k].e_stall));
      checkOutput($sformatf("vec%0d.issue", k),  32'(issue),  32'(vecs[k].e_issue));
      checkOutput($sformatf("vec%0d.fwd_rs", k), 32'(fwd_rs), 32'(vecs[k].e_fwd_rs));
      checkOutput($sformatf("vec%0d.fwd_rt", k), 32'(fwd_rt), 32'(vecs[k].e_fwd_rt));
      checkModel($sformatf("vec%0d", k));
      if (k == 12)
        checkOutput("r7.busy_two_writers", 32'(busy_mask[7]), 32'd1);
      advance();
    end
    #1;
    checkOutput("r0.busy", 32'(busy_mask[0]), 32'd0);

    // Flush kills the youngest entry (r9) but lets the older r10 retire
    repeat (3) step(idle, "drain");
    step(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0), "w10");
    step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0), "w9");
    applyStimulus(mk(1, 9, 0, 1, 0, 11, 1, 0, 1, 0, 0, 0, 0));
    checkOutput("flush.issue",  32'(issue),  32'd0);
    checkOutput("flush.fwd_rs", 32'(fwd_rs), 32'd1);
    checkModel("flush");
    advance();
    #1;
    checkOutput("flush.busy9",  32'(busy_mask[9]),  32'd0);
    checkOutput("flush.busy10", 32'(busy_mask[10]), 32'd1);
    checkOutput("flush.busy11", 32'(busy_mask[11]), 32'd0);
    step(idle, "postflush");
    #1;
    checkOutput("flush.r10_retired", 32'(busy_mask[10]), 32'd0);

    // Reset asserted while a load-use stall is active
    repeat (3) step(idle, "drain2");
    step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0), "lw5");
    dep = mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(dep);
    checkOutput("rst_mid.stall_before", 32'(stall), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_mid.stall",  32'(stall),     32'd0);
    checkOutput("rst_mid.issue",  32'(issue),     32'd1);
    checkOutput("rst_mid.fwd_rs", 32'(fwd_rs),    32'd0);
    checkOutput("rst_mid.busy",   32'(busy_mask), 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(dep);
    checkOutput("rst_release.issue", 32'(issue), 32'd1);
    checkModel("rst_release");
    advance();

    // Randomized traffic on a small register window to force hazards
    for (int n = 0; n < 400; n++) begin
      rv = idle;
      rv.valid  = ($urandom_range(0, 7) != 0);
      rv.rs     = AW'($urandom_range(0, 7));
      rv.rt     = AW'($urandom_range(0, 7));
      rv.use_rs = 1'($urandom_range(0, 1));
      rv.use_rt = 1'($urandom_range(0, 1));
      rv.rd     = AW'($urandom_range(0, 7));
      rv.reg_wr = ($urandom_range(0, 3) != 0);
      rv.mem_rd = ($urandom_range(0, 2) == 0);
      rv.fl     = ($urandom_range(0, 9) == 0);
      step(rv, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
